// File: rtl/uart_frame_streamer.sv
// uart_frame_streamer
//   Reads the sample memory one byte at a time once capture has finished and sends it to
//   uart_tx as a single framed packet:
//     HEADER, len[23:16], len[15:8], len[7:0], payload bytes, 8-bit payload checksum.
//   Each byte is paced by the uart_tx rdy handshake.
// Ports
//   i_clk_50M     system clock
//   i_rst         synchronous active-high reset
//   i_start       1-cycle pulse that starts a frame; accepted only in IDLE or DONE
//   i_len         payload byte count, sampled when i_start is accepted
//   o_mem_raddr   sample memory read address
//   i_mem_rdata   memory read data, valid one cycle after o_mem_raddr
//   o_uart_wreq   1-cycle write strobe to uart_tx
//   o_uart_wdata  byte for uart_tx, held from the strobe until the next strobe
//   i_uart_rdy    uart_tx ready/idle
//   o_busy        frame in progress
//   o_done        frame finished (DONE state)
//   o_cnt_sent    payload bytes handed to uart_tx in the current frame
module uart_frame_streamer #(
  parameter int unsigned       N_data = 8,
  parameter int unsigned       ADDR_W = 19,
  parameter logic [N_data-1:0] HEADER = 'hA5
) (
  input  logic              i_clk_50M,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [23:0]       i_len,
  output logic [ADDR_W-1:0] o_mem_raddr,
  input  logic [N_data-1:0] i_mem_rdata,
  output logic              o_uart_wreq,
  output logic [N_data-1:0] o_uart_wdata,
  input  logic              i_uart_rdy,
  output logic              o_busy,
  output logic              o_done,
  output logic [23:0]       o_cnt_sent
);

  typedef enum logic [3:0] {
    StIdle, StHdr, StLen0, StLen1, StLen2, StFetch, StWait, StSend, StCsum, StDone
  } state_e;

  state_e            r_state, w_state_next;
  logic [23:0]       r_len, r_idx, r_cnt;
  logic [N_data-1:0] r_csum, r_byte, r_wdata;
  logic              r_pend;

  logic              w_start_ok, w_can_send, w_wreq;
  logic [N_data-1:0] w_tx_byte;

  assign w_start_ok = i_start && (r_state == StIdle || r_state == StDone);
  // r_pend blocks the cycle right after a strobe; by then uart_tx has dropped rdy, so the
  // next strobe waits for rdy to come back, and with rdy stuck high spacing is still 2 cycles.
  assign w_can_send = i_uart_rdy && !r_pend;

  always_comb begin
    w_state_next = r_state;
    w_wreq       = 1'b0;
    w_tx_byte    = r_byte;
    unique case (r_state)
      StIdle: if (w_start_ok) w_state_next = StHdr;
      StHdr: begin
        w_tx_byte = HEADER;
        if (w_can_send) begin
          w_wreq       = 1'b1;
          w_state_next = StLen0;
        end
      end
      StLen0: begin
        w_tx_byte = N_data'(r_len[23:16]);
        if (w_can_send) begin
          w_wreq       = 1'b1;
          w_state_next = StLen1;
        end
      end
      StLen1: begin
        w_tx_byte = N_data'(r_len[15:8]);
        if (w_can_send) begin
          w_wreq       = 1'b1;
          w_state_next = StLen2;
        end
      end
      StLen2: begin
        w_tx_byte = N_data'(r_len[7:0]);
        if (w_can_send) begin
          w_wreq       = 1'b1;
          w_state_next = (r_len == 24'd0) ? StCsum : StFetch;
        end
      end
      StFetch: w_state_next = StWait;
      StWait:  w_state_next = StSend;
      StSend: begin
        w_tx_byte = r_byte;
        if (w_can_send) begin
          w_wreq       = 1'b1;
          w_state_next = (r_idx + 24'd1 == r_len) ? StCsum : StFetch;
        end
      end
      StCsum: begin
        w_tx_byte = r_csum;
        if (w_can_send) begin
          w_wreq       = 1'b1;
          w_state_next = StDone;
        end
      end
      StDone: if (w_start_ok) w_state_next = StHdr;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_50M) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_byte  <= '0;
      r_wdata <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_wreq;
      if (w_wreq) r_wdata <= w_tx_byte;
      if (w_start_ok) begin
        r_len  <= i_len;
        r_idx  <= '0;
        r_cnt  <= '0;
        r_csum <= '0;
      end
      if (r_state == StWait) r_byte <= i_mem_rdata;
      if (r_state == StSend && w_wreq) begin
        r_csum <= r_csum + r_byte;
        r_cnt  <= r_cnt + 24'd1;
        r_idx  <= r_idx + 24'd1;
      end
    end
  end

  // The strobe cycle shows the new byte directly; afterwards the registered copy holds it.
  assign o_uart_wreq  = w_wreq;
  assign o_uart_wdata = w_wreq ? w_tx_byte : r_wdata;
  assign o_mem_raddr  = r_idx[ADDR_W-1:0];
  assign o_busy       = (r_state != StIdle) && (r_state != StDone);
  assign o_done       = (r_state == StDone);
  assign o_cnt_sent   = r_cnt;

endmodule

// File: tb/tb_uart_frame_streamer.sv
module tb_uart_frame_streamer;

  logic        clk = 1'b0;
  logic        i_rst, i_start;
  logic [23:0] i_len;
  logic [18:0] o_mem_raddr;
  logic [7:0]  i_mem_rdata, o_uart_wdata;
  logic        o_uart_wreq, i_uart_rdy, o_busy, o_done;
  logic [23:0] o_cnt_sent;

  always #10 clk = ~clk;

  uart_frame_streamer #(.N_data(8), .ADDR_W(19), .HEADER(8'hA5)) dut (
    .i_clk_50M   (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_len       (i_len),
    .o_mem_raddr (o_mem_raddr),
    .i_mem_rdata (i_mem_rdata),
    .o_uart_wreq (o_uart_wreq),
    .o_uart_wdata(o_uart_wdata),
    .i_uart_rdy  (i_uart_rdy),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_cnt_sent  (o_cnt_sent)
  );

  // Sample memory with one cycle of read latency.
  logic [7:0] mem [256];
  always @(posedge clk) i_mem_rdata <= mem[o_mem_raddr[7:0]];

  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         hold_low = 1'b0;
  int         fixed_delay = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // uart_tx model: logs every strobe, drops rdy the following cycle and raises it again
  // after a fixed or random busy time; hold_low forces rdy low.
  initial begin
    int  cd;
    bit  w;
    cd = 0;
    i_uart_rdy = 1'b1;
    forever begin
      @(negedge clk);
      w = o_uart_wreq;
      if (w) begin
        rx_q.push_back(o_uart_wdata);
        check("rdy_at_wreq", {31'd0, i_uart_rdy}, 32'd1);
      end
      @(posedge clk);
      #1;
      if (w) begin
        i_uart_rdy = 1'b0;
        cd = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 12);
      end else if (cd > 0) begin
        cd--;
      end else begin
        i_uart_rdy = 1'b1;
      end
      if (hold_low) i_uart_rdy = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  // Expected wire bytes from the frame definition.
  task automatic build_exp(input logic [23:0] n);
    int sum;
    sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(n[23:16]);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(mem[i % 256]);
      sum = sum + int'(mem[i % 256]);
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!o_done && c < 5000) begin
      cycles(1);
      c++;
    end
    check({tag, "_done_in_time"}, {31'd0, (c < 5000)}, 32'd1);
    cycles(1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    int c;
    c = 0;
    while (rx_q.size() < n && c < 5000) begin
      cycles(1);
      c++;
    end
    check({tag, "_rx_in_time"}, {31'd0, (c < 5000)}, 32'd1);
  endtask

  task automatic compare_frame(input string tag, input logic [23:0] n);
    int m;
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    check({tag, "_done"}, {31'd0, o_done}, 32'd1);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_cnt_sent"}, o_cnt_sent, n);
  endtask

  task automatic run_frame(input logic [23:0] n, input string tag);
    i_len = n;
    build_exp(n);
    rx_q.delete();
    pulse_start();
    wait_done(tag);
    compare_frame(tag, n);
  endtask

  initial begin
    logic [23:0] n;
    i_rst   = 1'b1;
    i_start = 1'b1;  // coincident with reset: reset must win
    i_len   = 24'd9;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    cycles(3);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_wreq", {31'd0, o_uart_wreq}, 32'd0);
    check("rst_wdata", {24'd0, o_uart_wdata}, 32'd0);
    i_start = 1'b0;
    i_rst   = 1'b0;
    cycles(2);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_busy_after", {31'd0, o_busy}, 32'd0);
    check("rst_cnt", o_cnt_sent, 32'd0);
    check("rst_raddr", {13'd0, o_mem_raddr}, 32'd0);

    // 1: len=4, fixed 10-cycle uart, plus first-strobe latency.
    fixed_delay = 10;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    i_len = 24'd4;
    build_exp(24'd4);
    check("t1_model_csum", {24'd0, exp_q[8]}, 32'h0A);
    rx_q.delete();
    cycles(5);
    pulse_start();
    check("t1_first_wreq", {31'd0, o_uart_wreq}, 32'd1);
    check("t1_first_byte", {24'd0, o_uart_wdata}, 32'hA5);
    check("t1_busy", {31'd0, o_busy}, 32'd1);
    wait_done("t1");
    compare_frame("t1", 24'd4);
    fixed_delay = 0;

    // 2: empty payload, exactly 5 bytes.
    run_frame(24'd0, "t2");
    check("t2_raddr", {13'd0, o_mem_raddr}, 32'd0);

    // 3: checksum wraps.
    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h03;
    run_frame(24'd3, "t3");
    check("t3_csum", {24'd0, rx_q[rx_q.size()-1]}, 32'h01);

    // Randomised frames.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      n = 24'($urandom_range(1, 40));
      run_frame(n, $sformatf("rand%0d", k));
    end

    // 4: reset after two payload bytes, then a complete resend.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    i_len = 24'd8;
    rx_q.delete();
    pulse_start();
    wait_rx(6, "t4");
    i_rst = 1'b1;
    cycles(1);
    check("t4_busy", {31'd0, o_busy}, 32'd0);
    check("t4_wreq", {31'd0, o_uart_wreq}, 32'd0);
    check("t4_done", {31'd0, o_done}, 32'd0);
    check("t4_cnt", o_cnt_sent, 32'd0);
    i_rst = 1'b0;
    cycles(20);
    check("t4_no_partial", rx_q.size(), 32'd6);
    run_frame(24'd8, "t4_resend");

    // 5: rdy held low at start, extra starts ignored.
    hold_low = 1'b1;
    cycles(5);
    i_len = 24'd5;
    build_exp(24'd5);
    rx_q.delete();
    pulse_start();
    cycles(10);
    i_len = 24'd9;
    pulse_start();
    check("t5_busy_held", {31'd0, o_busy}, 32'd1);
    cycles(40);
    check("t5_no_wreq_low", rx_q.size(), 32'd0);
    hold_low = 1'b0;
    wait_rx(6, "t5");
    i_len = 24'd2;
    pulse_start();
    wait_done("t5");
    compare_frame("t5", 24'd5);

    // 6: back-to-back frame started from DONE.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run_frame(24'd2, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
